msg_catalog_lookup: RTL

Hardware message-catalog engine for localised UI/diagnostic strings. It maps a 32-bit message-id hash plus a language code to a translation-string index, gettext-style. It is parametrised in table depth, key/value width and language count, and is runtime-programmable with insert, update and delete. A miss in the requested language falls back to the source language (lang 0) and then to "untranslated". It sits between the message formatter and the string ROM.

---
 rtl/msgcat_pkg.sv | 43 ++++
 rtl/msgcat_table.sv | 76 +++++++
 rtl/msg_catalog_lookup.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/msgcat_pkg.sv
// Shared types for the message-catalog lookup engine.
//   state_t      : controller FSM states
//   lk_status_t  : lookup result code driven on resp_status
//   wr_status_t  : table-write result code driven on wr_status
//   entry_t      : one catalog entry, widths fixed by the type parameters below
package msgcat_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SCAN    = 3'd1,
    ST_FB_SCAN = 3'd2,
    ST_RESP    = 3'd3,
    ST_WDONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    LK_HIT    = 2'd0,
    LK_FB_HIT = 2'd1,
    LK_MISS   = 2'd2
  } lk_status_t;

  typedef enum logic [1:0] {
    WR_INSERTED = 2'd0,
    WR_UPDATED  = 2'd1,
    WR_DELETED  = 2'd2,
    WR_ERROR    = 2'd3
  } wr_status_t;

  // Default entry layout for the standard build (32-bit key, 16-bit value,
  // four languages). Modules built with other widths declare the same
  // layout locally from their own parameters.
  localparam int DEF_KEY_W = 32;
  localparam int DEF_VAL_W = 16;
  localparam int DEF_LW    = 2;

  typedef struct packed {
    logic                 valid;
    logic [DEF_LW-1:0]    lang;
    logic [DEF_KEY_W-1:0] key;
    logic [DEF_VAL_W-1:0] val;
  } entry_t;

endpackage

// File: rtl/msgcat_table.sv
// Catalog storage: DEPTH entries of {valid, lang, key, val}.
//   i_clr                  : invalidate every entry, count -> 0
//   i_rd_idx / o_rd_*      : one combinational indexed read port
//   i_wr_en / i_wr_*       : one write port; i_wr_valid=0 invalidates the slot
//   o_count                : number of valid entries, tracked incrementally
module msgcat_table
  import msgcat_pkg::*;
#(
  parameter int KEY_W = 32,
  parameter int VAL_W = 16,
  parameter int DEPTH = 16,
  parameter int LW    = 2,
  localparam int IW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic [IW-1:0]    i_rd_idx,
  output logic             o_rd_valid,
  output logic [KEY_W-1:0] o_rd_key,
  output logic [LW-1:0]    o_rd_lang,
  output logic [VAL_W-1:0] o_rd_val,
  input  logic             i_wr_en,
  input  logic [IW-1:0]    i_wr_idx,
  input  logic             i_wr_valid,
  input  logic [KEY_W-1:0] i_wr_key,
  input  logic [LW-1:0]    i_wr_lang,
  input  logic [VAL_W-1:0] i_wr_val,
  output logic [CW-1:0]    o_count
);

  typedef struct packed {
    logic [LW-1:0]    lang;
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } payload_t;

  logic [DEPTH-1:0] r_valid;
  payload_t         r_payload [DEPTH];
  logic [CW-1:0]    r_count;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_valid <= '0;
      r_count <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= i_wr_valid;
      if (i_wr_valid && !r_valid[i_wr_idx]) begin
        r_count <= r_count + CW'(1);
      end else if (!i_wr_valid && r_valid[i_wr_idx]) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // NOTE: only the valid bits need reset; payload contents are never
  // observed unless their valid bit is set, so the array stays reset-free.
  always_ff @(posedge clk) begin
    if (i_wr_en && i_wr_valid) begin
      r_payload[i_wr_idx] <= '{lang: i_wr_lang, key: i_wr_key, val: i_wr_val};
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_key   = r_payload[i_rd_idx].key;
  assign o_rd_lang  = r_payload[i_rd_idx].lang;
  assign o_rd_val   = r_payload[i_rd_idx].val;
  assign o_count    = r_count;

endmodule

// File: rtl/msg_catalog_lookup.sv
// Message-catalog lookup engine: maps {message-id hash, language} to a
// string-ROM index, falling back to language 0 when enabled.
//   clr                          : invalidate all entries (IDLE only)
//   req_* / resp_*               : lookup request and result handshakes
//   wr_*                         : insert/update/delete handshake
//   wr_done / wr_status          : one-cycle completion pulse and code
//   count                        : number of valid entries
// Both lookups and writes walk the table one entry per cycle in ST_SCAN.
module msg_catalog_lookup
  import msgcat_pkg::*;
#(
  parameter int KEY_W    = 32,
  parameter int VAL_W    = 16,
  parameter int DEPTH    = 16,
  parameter int LANGS    = 4,
  parameter int FALLBACK = 1,
  localparam int LW      = (LANGS > 1) ? $clog2(LANGS) : 1,
  localparam int IW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [KEY_W-1:0] req_key,
  input  logic [LW-1:0]    req_lang,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [VAL_W-1:0] resp_val,
  output logic [1:0]       resp_status,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic             wr_del,
  input  logic [KEY_W-1:0] wr_key,
  input  logic [LW-1:0]    wr_lang,
  input  logic [VAL_W-1:0] wr_val,
  output logic             wr_done,
  output logic [1:0]       wr_status,
  output logic [CW-1:0]    count
);

  state_t           r_state, w_state_nxt;
  logic [IW-1:0]    r_idx;
  logic             r_is_wr, r_del;
  logic [KEY_W-1:0] r_key;
  logic [LW-1:0]    r_lang;
  logic [VAL_W-1:0] r_wval;
  logic             r_free_found;
  logic [IW-1:0]    r_free_idx;
  lk_status_t       r_resp_status;
  logic [VAL_W-1:0] r_resp_val;
  wr_status_t       r_wr_status;

  logic             w_rd_valid;
  logic [KEY_W-1:0] w_rd_key;
  logic [LW-1:0]    w_rd_lang;
  logic [VAL_W-1:0] w_rd_val;
  logic [LW-1:0]    w_cmp_lang;
  logic             w_match, w_last, w_free_avail;
  logic [IW-1:0]    w_free_idx;

  logic             w_accept_req, w_accept_wr;
  logic             w_tbl_clr, w_tbl_we, w_tbl_wvalid;
  logic [IW-1:0]    w_tbl_widx;
  logic             w_resp_load, w_wdone_load;
  lk_status_t       w_resp_status_nxt;
  logic [VAL_W-1:0] w_resp_val_nxt;
  wr_status_t       w_wr_status_nxt;

  msgcat_table #(
    .KEY_W (KEY_W),
    .VAL_W (VAL_W),
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_tbl_clr),
    .i_rd_idx   (r_idx),
    .o_rd_valid (w_rd_valid),
    .o_rd_key   (w_rd_key),
    .o_rd_lang  (w_rd_lang),
    .o_rd_val   (w_rd_val),
    .i_wr_en    (w_tbl_we),
    .i_wr_idx   (w_tbl_widx),
    .i_wr_valid (w_tbl_wvalid),
    .i_wr_key   (r_key),
    .i_wr_lang  (r_lang),
    .i_wr_val   (r_wval),
    .o_count    (count)
  );

  assign req_ready = (r_state == ST_IDLE) && !clr && !wr_valid;
  assign wr_ready  = (r_state == ST_IDLE) && !clr;

  // The fallback pass retries the same key against the source language.
  assign w_cmp_lang   = (r_state == ST_FB_SCAN) ? '0 : r_lang;
  assign w_match      = w_rd_valid && (w_rd_key == r_key) && (w_rd_lang == w_cmp_lang);
  assign w_last       = (r_idx == IW'(DEPTH - 1));
  // The entry under the index counts as free if nothing lower was found.
  assign w_free_avail = r_free_found || !w_rd_valid;
  assign w_free_idx   = r_free_found ? r_free_idx : r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt       = r_state;
    w_accept_req      = 1'b0;
    w_accept_wr       = 1'b0;
    w_tbl_clr         = 1'b0;
    w_tbl_we          = 1'b0;
    w_tbl_wvalid      = 1'b0;
    w_tbl_widx        = r_idx;
    w_resp_load       = 1'b0;
    w_resp_status_nxt = LK_MISS;
    w_resp_val_nxt    = '0;
    w_wdone_load      = 1'b0;
    w_wr_status_nxt   = WR_ERROR;

    unique case (r_state)
      ST_IDLE: begin
        if (clr) begin
          w_tbl_clr = 1'b1;
        end else if (wr_valid) begin
          w_accept_wr = 1'b1;
          w_state_nxt = ST_SCAN;
        end else if (req_valid) begin
          w_accept_req = 1'b1;
          w_state_nxt  = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (r_is_wr) begin
          if (w_match) begin
            w_tbl_we        = 1'b1;
            w_tbl_wvalid    = !r_del;
            w_wr_status_nxt = r_del ? WR_DELETED : WR_UPDATED;
            w_wdone_load    = 1'b1;
            w_state_nxt     = ST_WDONE;
          end else if (w_last) begin
            w_wdone_load = 1'b1;
            w_state_nxt  = ST_WDONE;
            if (!r_del && w_free_avail) begin
              w_tbl_we        = 1'b1;
              w_tbl_wvalid    = 1'b1;
              w_tbl_widx      = w_free_idx;
              w_wr_status_nxt = WR_INSERTED;
            end
          end
        end else begin
          if (w_match) begin
            w_resp_load       = 1'b1;
            w_resp_status_nxt = LK_HIT;
            w_resp_val_nxt    = w_rd_val;
            w_state_nxt       = ST_RESP;
          end else if (w_last) begin
            if ((FALLBACK != 0) && (r_lang != '0)) begin
              w_state_nxt = ST_FB_SCAN;
            end else begin
              w_resp_load = 1'b1;
              w_state_nxt = ST_RESP;
            end
          end
        end
      end

      ST_FB_SCAN: begin
        if (w_match) begin
          w_resp_load       = 1'b1;
          w_resp_status_nxt = LK_FB_HIT;
          w_resp_val_nxt    = w_rd_val;
          w_state_nxt       = ST_RESP;
        end else if (w_last) begin
          w_resp_load = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end

      ST_RESP: begin
        if (resp_ready) w_state_nxt = ST_IDLE;
      end

      ST_WDONE: w_state_nxt = ST_IDLE;

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx         <= '0;
      r_is_wr       <= 1'b0;
      r_del         <= 1'b0;
      r_key         <= '0;
      r_lang        <= '0;
      r_wval        <= '0;
      r_free_found  <= 1'b0;
      r_free_idx    <= '0;
      r_resp_status <= LK_HIT;
      r_resp_val    <= '0;
      r_wr_status   <= WR_INSERTED;
    end else begin
      if (w_accept_wr) begin
        r_is_wr <= 1'b1;
        r_del   <= wr_del;
        r_key   <= wr_key;
        r_lang  <= wr_lang;
        r_wval  <= wr_val;
      end else if (w_accept_req) begin
        r_is_wr <= 1'b0;
        r_del   <= 1'b0;
        r_key   <= req_key;
        r_lang  <= req_lang;
      end

      // Any state change (accept, SCAN -> FB_SCAN, scan exit) restarts the walk.
      if (w_state_nxt != r_state) begin
        r_idx <= '0;
      end else if (r_state == ST_SCAN || r_state == ST_FB_SCAN) begin
        r_idx <= r_idx + IW'(1);
      end

      if (w_accept_wr) begin
        r_free_found <= 1'b0;
      end else if (r_state == ST_SCAN && r_is_wr && !w_rd_valid && !r_free_found) begin
        r_free_found <= 1'b1;
        r_free_idx   <= r_idx;
      end

      if (w_resp_load) begin
        r_resp_status <= w_resp_status_nxt;
        r_resp_val    <= w_resp_val_nxt;
      end

      if (w_wdone_load) r_wr_status <= w_wr_status_nxt;
    end
  end

  assign resp_valid  = (r_state == ST_RESP);
  assign resp_val    = r_resp_val;
  assign resp_status = r_resp_status;
  assign wr_done     = (r_state == ST_WDONE);
  assign wr_status   = r_wr_status;

endmodule
